ask_mod: RTL and testbench
==========================

// Module: ask_mod
// PURPOSE
//  On-off-keyed (ASK) transmitter for the 10-bit DAC path; counterpart of the ASK demodulator.
//  Accepts a serial bit stream over a valid/ready handshake and emits offset-binary DAC samples.
//  Bit rate is selectable at 6/8/10 kbps. A '1' bit is a sine carrier from a 32-bit NCO; a '0' bit is silence (mid-code 512).
// PARAMETERS
//  BIT_CYC_6K   5000  clk cycles per bit at 6 kbps (30 MHz clk)
//  BIT_CYC_8K   3750  clk cycles per bit at 8 kbps
//  BIT_CYC_10K  3000  clk cycles per bit at 10 kbps
//  RAMP_INC     4     envelope step per clk (ramp feature only)
// PORTS
//  clk        in   1   sample clock (30 MHz)
//  rst_n      in   1   asynchronous, active-low reset
//  en         in   1   transmitter enable; low forces IDLE
//  rate_kbps  in   4   6/8/10; any other value is treated as 6
//  freq_word  in   32  NCO increment; f_carrier = freq_word*f_clk/2^32
//  amp        in   9   peak amplitude in LSB (0..511)
//  s_bit      in   1   bit to send
//  s_valid    in   1   s_bit valid
//  s_ready    out  1   holding register empty and en=1
//  dac_data   out  10  offset-binary DAC sample, 512 = zero
//  bit_strobe out  1   1-clk pulse at each bit boundary (new bit starts)
//  underrun   out  1   1-clk pulse: boundary reached with holding register empty
//  busy       out  1   state == RUN
// BEHAVIOUR
//  Reset: dac_data=512, s_ready=0, bit_strobe=0, underrun=0, busy=0; NCO phase=0; holding register empty; state=IDLE.
//  Handshake: transfer occurs when s_valid&&s_ready. s_ready = en && !hold_full, registered.
//   - No bypass: a bit accepted on a boundary cycle waits for the next boundary.
//  FSM IDLE: bit counter=0, phase=0, cur_bit=0.
//   - Go to RUN when en=1 and hold_full. On entry: load cur_bit from hold, pulse bit_strobe, latch bit_cyc.
//  FSM RUN: bit counter (16 b) counts 0..bit_cyc-1.
//   - At bit_cyc-1 (boundary): rate_kbps is re-sampled into bit_cyc and bit_strobe pulses.
//   - If hold_full: cur_bit<=hold, hold emptied.
//   - Else: cur_bit<=0, underrun pulses, stay RUN (silence bit).
//  en=0 in any state: next clk state=IDLE, hold flushed, phase=0, counters cleared, s_ready=0.
//   - dac_data reaches 512 within 2 clk.
//  rate_kbps changes mid-bit take effect only at the next boundary; the current bit length is unchanged.
//  NCO: phase += freq_word every clk in RUN; 32-bit wrap-around is intended.
//   - phase[31:24] addresses a 64-entry quarter-wave sine LUT (9-bit unsigned magnitude, 0..511), using symmetry for quadrants.
//  Datapath (registered, 2-stage):
//   - Stage 1: mag = LUT.
//   - Stage 2: prod = (mag*env)>>9, 9 b.
//   - Output: dac_data = 512 +/- prod, sign from quadrant; result clamped to 1..1023.
//   - env = amp when cur_bit=1, else 0.
//  Latency: cur_bit/phase change at boundary cycle T is visible on dac_data at T+2.
//  amp=0 or freq_word=0: dac_data constant 512 (or constant offset for freq_word=0 at phase 0 -> 512).
// CONFIGURATION
//  ASK_MOD_RAMP_EN defined:
//   - env is a 9-bit register that moves toward target (amp or 0) by RAMP_INC per clk and saturates exactly at target.
//   - Gives a soft keying envelope. en=0 clears env immediately.
//  ASK_MOD_RAMP_EN undefined: env = target combinationally (hard keying); no env register.
// TESTING
//  1 Reset asserted -> dac_data=512, s_ready=0, busy=0, bit_strobe=0, underrun=0.
//  2 en=1, rate=6, amp=511, freq_word=0x1111_1111, send 1,0,1:
//    - bit_strobe spacing 5000 clk.
//    - Bit 1: dac_data swings ~1..1023. Bit 0: dac_data==512 (from T+2).
//  3 rate=10 -> strobe spacing 3000; rate=7 -> spacing 5000.
//    - rate changed 6->8 mid-bit -> current bit stays 5000, next bit 3750.
//  4 Stop s_valid after bit 1 -> at next boundary underrun=1 for 1 clk, busy stays 1, dac_data==512.
//  5 en dropped mid '1' bit -> busy=0 next clk, s_ready=0, dac_data==512 within 2 clk.
//    - Re-enable with queued bit -> phase restarts at 0.
//  6 With ASK_MOD_RAMP_EN, amp=400, RAMP_INC=4, bit 0->1:
//    - Envelope reaches 400 after 100 clk, no overshoot.
//    - Ramp back to 0 after 1->0.

Source files
------------

// File: rtl/ask_mod.sv
// ask_mod: on-off-keyed (ASK) transmitter feeding a 10-bit offset-binary DAC.
// Define ASK_MOD_RAMP_EN for a soft keying envelope; otherwise keying is hard.
module ask_mod #(
    parameter int unsigned BIT_CYC_6K  = 5000,
    parameter int unsigned BIT_CYC_8K  = 3750,
    parameter int unsigned BIT_CYC_10K = 3000
`ifdef ASK_MOD_RAMP_EN
    ,
    parameter int unsigned RAMP_INC    = 4
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [3:0]  rate_kbps,
    input  logic [31:0] freq_word,
    input  logic [8:0]  amp,
    input  logic        s_bit,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [9:0]  dac_data,
    output logic        bit_strobe,
    output logic        underrun,
    output logic        busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Quarter-wave sine, round(511*sin(i*pi/128)), i = 0..63.
    // NOTE: this is a constant ROM, so it takes no reset; only state flops are reset.
    localparam logic [8:0] SINE_LUT [64] = '{
        9'd0,   9'd13,  9'd25,  9'd38,  9'd50,  9'd63,  9'd75,  9'd87,
        9'd100, 9'd112, 9'd124, 9'd136, 9'd148, 9'd160, 9'd172, 9'd184,
        9'd196, 9'd207, 9'd218, 9'd230, 9'd241, 9'd252, 9'd263, 9'd273,
        9'd284, 9'd294, 9'd304, 9'd314, 9'd324, 9'd334, 9'd343, 9'd352,
        9'd361, 9'd370, 9'd379, 9'd387, 9'd395, 9'd403, 9'd410, 9'd418,
        9'd425, 9'd432, 9'd438, 9'd445, 9'd451, 9'd456, 9'd462, 9'd467,
        9'd472, 9'd477, 9'd481, 9'd485, 9'd489, 9'd492, 9'd496, 9'd499,
        9'd501, 9'd503, 9'd505, 9'd507, 9'd509, 9'd510, 9'd510, 9'd511
    };

    function automatic logic [15:0] rate_to_cyc(input logic [3:0] rate);
        case (rate)
            4'd8:    return 16'(BIT_CYC_8K);
            4'd10:   return 16'(BIT_CYC_10K);
            default: return 16'(BIT_CYC_6K);
        endcase
    endfunction

    logic [0:0]  state;
    logic        hold_full;
    logic        hold_full_nxt;
    logic        hold_bit;
    logic        cur_bit;
    logic [15:0] bit_cnt;
    logic [15:0] bit_cyc;
    logic [31:0] phase;
    logic        accept;
    logic        boundary;
    logic        consume;

    assign accept   = s_valid && s_ready;
    assign boundary = (state == ST_RUN) && (bit_cnt == bit_cyc - 16'd1);
    // A queued bit leaves the holding register on RUN entry or at a boundary.
    assign consume  = en && hold_full && ((state == ST_IDLE) || boundary);
    assign busy     = (state == ST_RUN);

    // NOTE: defaults first in every always_comb so no path can infer a latch.
    always_comb begin
        hold_full_nxt = hold_full;
        if (!en) begin
            hold_full_nxt = 1'b0;
        end else if (consume) begin
            hold_full_nxt = 1'b0;
        end else if (accept) begin
            hold_full_nxt = 1'b1;
        end
    end

    // s_ready looks at the next holding state so a full register never takes a second bit.
    // NOTE: non-blocking (<=) in clocked blocks so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            hold_bit  <= 1'b0;
            s_ready   <= 1'b0;
        end else begin
            hold_full <= hold_full_nxt;
            if (accept) begin
                hold_bit <= s_bit;
            end
            s_ready <= en && !hold_full_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cur_bit    <= 1'b0;
            bit_cnt    <= '0;
            bit_cyc    <= 16'(BIT_CYC_6K);
            phase      <= '0;
            bit_strobe <= 1'b0;
            underrun   <= 1'b0;
        end else if (!en) begin
            state      <= ST_IDLE;
            cur_bit    <= 1'b0;
            bit_cnt    <= '0;
            phase      <= '0;
            bit_strobe <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bit_cnt    <= '0;
                    phase      <= '0;
                    cur_bit    <= 1'b0;
                    bit_strobe <= 1'b0;
                    underrun   <= 1'b0;
                    if (hold_full) begin
                        state      <= ST_RUN;
                        cur_bit    <= hold_bit;
                        bit_strobe <= 1'b1;
                        bit_cyc    <= rate_to_cyc(rate_kbps);
                    end
                end
                default: begin
                    phase      <= phase + freq_word;
                    bit_strobe <= 1'b0;
                    underrun   <= 1'b0;
                    if (boundary) begin
                        bit_cnt    <= '0;
                        bit_cyc    <= rate_to_cyc(rate_kbps);
                        bit_strobe <= 1'b1;
                        cur_bit    <= hold_full ? hold_bit : 1'b0;
                        underrun   <= !hold_full;
                    end else begin
                        bit_cnt <= bit_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    logic [8:0] env_target;
    logic [8:0] env;

    assign env_target = cur_bit ? amp : 9'd0;

`ifdef ASK_MOD_RAMP_EN
    localparam logic [8:0] RAMP_STEP = 9'(RAMP_INC);
    logic [8:0] env_r;

    // Slew toward the target and land on it exactly, never stepping past.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            env_r <= '0;
        end else if (!en) begin
            env_r <= '0;
        end else if (env_r < env_target) begin
            env_r <= (env_target - env_r > RAMP_STEP) ? env_r + RAMP_STEP : env_target;
        end else if (env_r > env_target) begin
            env_r <= (env_r - env_target > RAMP_STEP) ? env_r - RAMP_STEP : env_target;
        end
    end

    assign env = env_r;
`else
    assign env = env_target;
`endif

    // Quadrants 1 and 3 read the table mirrored; quadrants 2 and 3 are negative.
    logic [5:0]  lut_idx;
    logic [8:0]  mag_s1;
    logic        neg_s1;
    logic [8:0]  env_s1;
    logic [8:0]  prod;
    logic [10:0] sum;
    logic [9:0]  dac_next;

    assign lut_idx = phase[30] ? ~phase[29:24] : phase[29:24];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_s1 <= '0;
            neg_s1 <= 1'b0;
            env_s1 <= '0;
        end else begin
            mag_s1 <= SINE_LUT[lut_idx];
            neg_s1 <= phase[31];
            env_s1 <= en ? env : 9'd0;
        end
    end

    always_comb begin
        prod     = 9'((18'(mag_s1) * 18'(env_s1)) >> 9);
        sum      = neg_s1 ? (11'd512 - 11'(prod)) : (11'd512 + 11'(prod));
        dac_next = sum[9:0];
        if (sum == 11'd0) begin
            dac_next = 10'd1;
        end else if (sum > 11'd1023) begin
            dac_next = 10'd1023;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_data <= 10'd512;
        end else begin
            dac_data <= dac_next;
        end
    end

endmodule

// File: tb/tb_ask_mod.sv
// tb_ask_mod: scoreboard bench for ask_mod; a monitor turns each transmitted
// bit into a record that is matched against the bits the tests queued.
module tb_ask_mod;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  rate_kbps = 4'd6;
    logic [31:0] freq_word = '0;
    logic [8:0]  amp = '0;
    logic        s_bit = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [9:0]  dac_data;
    logic        bit_strobe;
    logic        underrun;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;

    ask_mod dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .rate_kbps  (rate_kbps),
        .freq_word  (freq_word),
        .amp        (amp),
        .s_bit      (s_bit),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .dac_data   (dac_data),
        .bit_strobe (bit_strobe),
        .underrun   (underrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // kind: 0 = silent (512), 1 = full-scale carrier, 3 = carrier starting at phase 0
    typedef struct {
        int len;
        int kind;
        bit und;
    } exp_t;

    typedef struct {
        int             len;
        bit             und;
        logic [9:0]     mn;
        logic [9:0]     mx;
        logic [9:0]     last;
        logic [3:0][9:0] head;
    } rec_t;

    exp_t exp_q[$];
    rec_t obs_q[$];

    int   cyc = 0;
    int   start_cyc = 0;
    bit   bit_open = 1'b0;
    int   und_hi = 0;
    rec_t cur;

    // Samples before offset 2 still show the previous bit (two-stage datapath).
    always @(negedge clk) begin
        cyc++;
        if (underrun) und_hi++;
        if (!busy) begin
            bit_open = 1'b0;
        end else begin
            if (bit_strobe) begin
                if (bit_open) begin
                    cur.len = cyc - start_cyc;
                    obs_q.push_back(cur);
                end
                bit_open  = 1'b1;
                start_cyc = cyc;
                cur.und   = underrun;
                cur.mn    = 10'd1023;
                cur.mx    = 10'd0;
                cur.last  = 10'd0;
                cur.head  = '0;
            end
            if (bit_open && (cyc - start_cyc) >= 2) begin
                if (dac_data < cur.mn) cur.mn = dac_data;
                if (dac_data > cur.mx) cur.mx = dac_data;
                cur.last = dac_data;
                if ((cyc - start_cyc) <= 5) cur.head[cyc - start_cyc - 2] = dac_data;
            end
        end
    end

    // kind < 0 sends the bit without expecting a record for it.
    task automatic send_bit(input bit b, input int len, input int kind);
        int n = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_bit   = b;
        while (!s_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: s_ready got %b after %0d clk, want 1", s_ready, n);
            s_valid = 1'b0;
            return;
        end
        if (kind >= 0) exp_q.push_back('{len, kind, 1'b0});
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_recs(input int n);
        int k = 0;
        while (obs_q.size() < n && k < 30000) begin
            @(negedge clk);
            k++;
        end
        tests_run++;
        if (obs_q.size() < n) begin
            tests_failed++;
            $display("FAIL wait_recs: got %0d bit records, want %0d", obs_q.size(), n);
        end
    endtask

    task automatic end_test;
        @(negedge clk);
        en      = 1'b0;
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic drain_scoreboard;
        exp_t e;
        rec_t o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("FAIL bit_missing: got no record, want len %0d kind %0d", e.len, e.kind);
                continue;
            end
            o = obs_q.pop_front();
            if (o.len !== e.len) begin
                tests_failed++;
                $display("FAIL bit_len: got %0d, want %0d", o.len, e.len);
            end
            tests_run++;
            if (o.und !== e.und) begin
                tests_failed++;
                $display("FAIL underrun_at_start: got %b, want %b", o.und, e.und);
            end
            tests_run++;
            if (e.kind == 0) begin
`ifdef ASK_MOD_RAMP_EN
                if (o.last !== 10'd512) begin
                    tests_failed++;
                    $display("FAIL silent_bit: got last %0d, want 512", o.last);
                end
`else
                if (o.mn !== 10'd512 || o.mx !== 10'd512) begin
                    tests_failed++;
                    $display("FAIL silent_bit: got min %0d max %0d, want 512/512", o.mn, o.mx);
                end
`endif
            end else begin
                if (o.mx < 10'd1000 || o.mn > 10'd24) begin
                    tests_failed++;
                    $display("FAIL carrier_swing: got min %0d max %0d, want <=24 / >=1000", o.mn, o.mx);
                end
            end
            if (e.kind == 3) begin
                tests_run++;
                if (o.head[0] !== 10'd512 || o.head[2] !== 10'd512) begin
                    tests_failed++;
                    $display("FAIL phase_restart_zero: got %0d,%0d, want 512,512", o.head[0], o.head[2]);
                end
`ifndef ASK_MOD_RAMP_EN
                tests_run++;
                if (o.head[1] < 10'd1000 || o.head[3] > 10'd24) begin
                    tests_failed++;
                    $display("FAIL phase_restart_peak: got %0d,%0d, want >=1000,<=24", o.head[1], o.head[3]);
                end
`endif
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin
            tests_failed++;
            $display("FAIL extra_records: got %0d, want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_reset;
        en = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (dac_data !== 10'd512 || s_ready !== 1'b0 || busy !== 1'b0 ||
            bit_strobe !== 1'b0 || underrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got dac %0d rdy %b busy %b strb %b und %b, want 512 0 0 0 0",
                     dac_data, s_ready, busy, bit_strobe, underrun);
        end
        en    = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        en = 1'b1; rate_kbps = 4'd6; amp = 9'd511; freq_word = 32'h1111_1111;
        send_bit(1'b1, 5000, 1);
        send_bit(1'b0, 5000, 0);
        send_bit(1'b1, 5000, 1);
        wait_recs(3);
        drain_scoreboard();
        end_test();
    endtask

    task automatic test_rates;
        en = 1'b1; rate_kbps = 4'd10; amp = 9'd511; freq_word = 32'h1111_1111;
        send_bit(1'b1, 3000, 1);
        send_bit(1'b1, 3000, 1);
        wait_recs(2);
        drain_scoreboard();
        end_test();
        en = 1'b1; rate_kbps = 4'd7;
        send_bit(1'b0, 5000, 0);
        wait_recs(1);
        drain_scoreboard();
        end_test();
        // 6 -> 8 while the first bit runs: only the following bits shorten.
        en = 1'b1; rate_kbps = 4'd6;
        send_bit(1'b1, 5000, 1);
        send_bit(1'b0, 3750, 0);
        repeat (1000) @(negedge clk);
        rate_kbps = 4'd8;
        send_bit(1'b1, 3750, 1);
        wait_recs(3);
        drain_scoreboard();
        end_test();
    endtask

    task automatic test_underrun;
        int und_base;
        en = 1'b1; rate_kbps = 4'd8; amp = 9'd511; freq_word = 32'h1111_1111;
        und_base = und_hi;
        send_bit(1'b1, 3750, 1);
        exp_q.push_back('{3750, 0, 1'b1});
        wait_recs(2);
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL underrun_busy: got %b, want 1", busy);
        end
        tests_run++;
        if (und_hi - und_base !== 2) begin
            tests_failed++;
            $display("FAIL underrun_pulses: got %0d high clk, want 2", und_hi - und_base);
        end
        drain_scoreboard();
        end_test();
    endtask

    task automatic test_disable;
        int bad = 0;
        en = 1'b1; rate_kbps = 4'd10; amp = 9'd511; freq_word = 32'h4000_0000;
        send_bit(1'b1, 0, -1);
        send_bit(1'b0, 0, -1);
        repeat (1001) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL disable_flags: got busy %b rdy %b, want 0 0", busy, s_ready);
        end
        @(negedge clk);
        tests_run++;
        if (dac_data !== 10'd512) begin
            tests_failed++;
            $display("FAIL disable_dac: got %0d, want 512", dac_data);
        end
        en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL hold_flushed: got busy for %0d clk, want 0", bad);
        end
        send_bit(1'b1, 3000, 3);
        wait_recs(1);
        drain_scoreboard();
        end_test();
    endtask

    task automatic test_flat;
        en = 1'b1; rate_kbps = 4'd10; amp = 9'd0; freq_word = 32'h1111_1111;
        send_bit(1'b1, 3000, 0);
        wait_recs(1);
        drain_scoreboard();
        end_test();
        en = 1'b1; amp = 9'd511; freq_word = 32'h0;
        send_bit(1'b1, 3000, 0);
        wait_recs(1);
        drain_scoreboard();
        end_test();
    endtask

`ifdef ASK_MOD_RAMP_EN
    task automatic test_ramp;
        int         n = 0;
        int         bad = 0;
        logic [9:0] mx = '0;
        en = 1'b1; rate_kbps = 4'd10; amp = 9'd400; freq_word = 32'h4000_0000;
        send_bit(1'b0, 0, -1);
        send_bit(1'b1, 0, -1);
        do begin @(negedge clk); n++; end while (!bit_strobe && n < 4000);
        tests_run++;
        if (!bit_strobe) begin
            tests_failed++;
            $display("FAIL ramp_start: got no strobe in %0d clk, want one", n);
        end
        for (int k = 1; k <= 140; k++) begin
            @(negedge clk);
            if (dac_data > mx) mx = dac_data;
            if (k == 90) begin
                tests_run++;
                if (mx >= 10'd905) begin
                    tests_failed++;
                    $display("FAIL ramp_early: got peak %0d by clk 90, want <905", mx);
                end
            end
        end
        tests_run++;
        if (mx < 10'd905 || mx > 10'd912) begin
            tests_failed++;
            $display("FAIL ramp_peak: got %0d, want 905..912", mx);
        end
        send_bit(1'b0, 0, -1);
        n = 0;
        do begin @(negedge clk); n++; end while (!bit_strobe && n < 4000);
        repeat (110) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (dac_data !== 10'd512) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL ramp_down: got %0d non-512 samples, want 0", bad);
        end
        end_test();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_rates();
        test_underrun();
        test_disable();
        test_flat();
`ifdef ASK_MOD_RAMP_EN
        test_ramp();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
